// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pcs_pkg
// Brief   : 8b/10b code-group constants and PCS transmit state encoding.
//           Config states exist only when PCS_TX_CONFIG_EN is defined.
// Revision: 1.0
// ============================================================================
package pcs_pkg;

    localparam logic [7:0] c_K28_5 = 8'hBC;
    localparam logic [7:0] c_K27_7 = 8'hFB;
    localparam logic [7:0] c_K29_7 = 8'hFD;
    localparam logic [7:0] c_K23_7 = 8'hF7;
    localparam logic [7:0] c_K30_7 = 8'hFE;
    localparam logic [7:0] c_D5_6  = 8'hC5;
    localparam logic [7:0] c_D16_2 = 8'h50;
    localparam logic [7:0] c_D21_5 = 8'hB5;
    localparam logic [7:0] c_D2_2  = 8'h42;

    typedef enum logic [3:0] {
        IDLE_K = 4'd0,
        IDLE_D = 4'd1,
        START  = 4'd2,
        DATA   = 4'd3,
        END_T  = 4'd4,
        END_R  = 4'd5,
        END_R2 = 4'd6
`ifdef PCS_TX_CONFIG_EN
        ,
        CFG_K  = 4'd7,
        CFG_D  = 4'd8,
        CFG_LO = 4'd9,
        CFG_HI = 4'd10
`endif
    } pcs_state_e;

endpackage : pcs_pkg
`default_nettype wire

// File: rtl/pcs_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pcs_tx_ctrl
// Brief   : PCS transmit ordering: idles, /S/ data /T/R/ framing, underrun /V/.
//           Define PCS_TX_CONFIG_EN to add /C1/C2/ configuration ordered sets.
// Revision: 1.0
// ============================================================================
module pcs_tx_ctrl
    import pcs_pkg::*;
#(
    parameter int IPG_MIN = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_last,
    output logic        tx_ready,
    input  logic        enc_rd,
    output logic [7:0]  enc_data,
    output logic        enc_control,
`ifdef PCS_TX_CONFIG_EN
    input  logic        xmit_config,
    input  logic [15:0] cfg_word,
`endif
    output logic        tx_underrun
);

    localparam int            CW    = $clog2(IPG_MIN + 3);
    localparam logic [CW-1:0] c_IPG = CW'(IPG_MIN);

    pcs_state_e    state_q, state_d;
    logic          parity_q, parity_d;
    logic          rd_q, rd_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          drop_q, drop_d;
    logic [7:0]    enc_data_q, enc_data_d;
    logic          enc_control_q, enc_control_d;
    logic          tx_ready_q, tx_ready_d;
    logic          underrun_q, underrun_d;
    logic          cfg_c2_q, cfg_c2_d;

    logic          w_accept;
    logic          w_cfg_req;
    logic [CW-1:0] w_idle_sat;
    pcs_state_e    w_entry;

    assign w_accept = tx_valid & tx_ready_q;

    // The idle counter counts code-groups, so each /I/ ordered set adds two.
    assign w_idle_sat = (idle_cnt_q >= c_IPG) ? c_IPG : idle_cnt_q + CW'(2);

`ifdef PCS_TX_CONFIG_EN
    assign w_cfg_req = xmit_config;
    assign w_entry   = xmit_config ? CFG_K : IDLE_K;
`else
    assign w_cfg_req = 1'b0;
    assign w_entry   = IDLE_K;
`endif

    always_comb begin
        state_d       = state_q;
        parity_d      = ~parity_q;
        rd_d          = rd_q;
        idle_cnt_d    = idle_cnt_q;
        drop_d        = drop_q;
        enc_data_d    = c_K28_5;
        enc_control_d = 1'b1;
        underrun_d    = 1'b0;
        cfg_c2_d      = cfg_c2_q;

        // Leftover bytes of an underrun frame are swallowed until tx_last.
        if (drop_q && w_accept && tx_last) begin
            drop_d = 1'b0;
        end

        case (state_q)
            IDLE_K: begin
                rd_d    = enc_rd;
                state_d = IDLE_D;
            end
            IDLE_D: begin
                enc_data_d    = rd_q ? c_D5_6 : c_D16_2;
                enc_control_d = 1'b0;
                idle_cnt_d    = w_idle_sat;
                if (tx_valid && !drop_q && !w_cfg_req && (w_idle_sat >= c_IPG)) begin
                    state_d = START;
                end else begin
                    state_d = w_entry;
                end
            end
            START: begin
                enc_data_d = c_K27_7;
                idle_cnt_d = '0;
                state_d    = DATA;
            end
            DATA: begin
                if (tx_valid) begin
                    enc_data_d    = tx_data;
                    enc_control_d = 1'b0;
                    if (tx_last) begin
                        state_d = END_T;
                    end
                end else begin
                    enc_data_d = c_K30_7;
                    underrun_d = 1'b1;
                    drop_d     = 1'b1;
                    state_d    = END_T;
                end
            end
            END_T: begin
                enc_data_d = c_K29_7;
                state_d    = END_R;
            end
            END_R: begin
                enc_data_d = c_K23_7;
                state_d    = parity_q ? w_entry : END_R2;
            end
            END_R2: begin
                enc_data_d = c_K23_7;
                state_d    = w_entry;
            end
`ifdef PCS_TX_CONFIG_EN
            CFG_K: begin
                state_d = CFG_D;
            end
            CFG_D: begin
                enc_data_d    = cfg_c2_q ? c_D2_2 : c_D21_5;
                enc_control_d = 1'b0;
                state_d       = CFG_LO;
            end
            CFG_LO: begin
                enc_data_d    = cfg_word[7:0];
                enc_control_d = 1'b0;
                state_d       = CFG_HI;
            end
            CFG_HI: begin
                enc_data_d    = cfg_word[15:8];
                enc_control_d = 1'b0;
                cfg_c2_d      = xmit_config ? ~cfg_c2_q : 1'b0;
                state_d       = xmit_config ? CFG_K : IDLE_K;
            end
`endif
            default: begin
                state_d = IDLE_K;
            end
        endcase

        tx_ready_d = (state_d == DATA) ||
                     (drop_d && !(state_d inside {START, DATA, END_T, END_R, END_R2}));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE_K;
            parity_q      <= 1'b0;
            rd_q          <= 1'b0;
            idle_cnt_q    <= c_IPG;
            drop_q        <= 1'b0;
            enc_data_q    <= c_K28_5;
            enc_control_q <= 1'b1;
            tx_ready_q    <= 1'b0;
            underrun_q    <= 1'b0;
            cfg_c2_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            parity_q      <= parity_d;
            rd_q          <= rd_d;
            idle_cnt_q    <= idle_cnt_d;
            drop_q        <= drop_d;
            enc_data_q    <= enc_data_d;
            enc_control_q <= enc_control_d;
            tx_ready_q    <= tx_ready_d;
            underrun_q    <= underrun_d;
            cfg_c2_q      <= cfg_c2_d;
        end
    end

    assign enc_data    = enc_data_q;
    assign enc_control = enc_control_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = underrun_q;

endmodule : pcs_tx_ctrl
`default_nettype wire
